// File: rtl/id_ex_stage_pkg.sv
// Shared widths, ALU operation codes and the bubble control word for the ID/EX stage.
package id_ex_stage_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_W  = 5;
  localparam int DEF_OP_W   = 6;
  localparam int PC_W       = 32;

  localparam logic [DEF_OP_W-1:0] ALU_ADDU = 6'd0;
  localparam logic [DEF_OP_W-1:0] ALU_SUBU = 6'd1;
  localparam logic [DEF_OP_W-1:0] ALU_ORR  = 6'd2;
  localparam logic [DEF_OP_W-1:0] ALU_LUI  = 6'd3;
  localparam logic [DEF_OP_W-1:0] ALU_EQU  = 6'd4;

  typedef struct packed {
    logic valid;
    logic reg_write;
    logic src_b;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '{valid: 1'b0, reg_write: 1'b0, src_b: 1'b0};

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle of decode-side inputs, producer tuples, hazard controls and ALU-side outputs.
interface id_ex_stage_if
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_W  = DEF_REG_W,
  parameter int OP_W   = DEF_OP_W
);
  logic              stall;
  logic              flush;
  logic              idValid;
  logic [PC_W-1:0]   idPc;
  logic [DATA_W-1:0] idRsVal;
  logic [DATA_W-1:0] idRtVal;
  logic [DATA_W-1:0] idImm;
  logic [REG_W-1:0]  idRs;
  logic [REG_W-1:0]  idRt;
  logic [OP_W-1:0]   idAluOp;
  logic              idSrcB;
  logic              idRegWrite;
  logic [REG_W-1:0]  idWriteReg;
  logic              memRegWrite;
  logic [REG_W-1:0]  memWriteReg;
  logic [DATA_W-1:0] memData;
  logic              wbRegWrite;
  logic [REG_W-1:0]  wbWriteReg;
  logic [DATA_W-1:0] wbData;
  logic [DATA_W-1:0] aluA;
  logic [DATA_W-1:0] aluB;
  logic [OP_W-1:0]   aluOp;
  logic [DATA_W-1:0] exRtVal;
  logic              exValid;
  logic [PC_W-1:0]   exPc;
  logic              exRegWrite;
  logic [REG_W-1:0]  exWriteReg;

  modport master (
    output stall, flush, idValid, idPc, idRsVal, idRtVal, idImm, idRs, idRt,
           idAluOp, idSrcB, idRegWrite, idWriteReg,
           memRegWrite, memWriteReg, memData, wbRegWrite, wbWriteReg, wbData,
    input  aluA, aluB, aluOp, exRtVal, exValid, exPc, exRegWrite, exWriteReg
  );

  modport slave (
    input  stall, flush, idValid, idPc, idRsVal, idRtVal, idImm, idRs, idRt,
           idAluOp, idSrcB, idRegWrite, idWriteReg,
           memRegWrite, memWriteReg, memData, wbRegWrite, wbWriteReg, wbData,
    output aluA, aluB, aluOp, exRtVal, exValid, exPc, exRegWrite, exWriteReg
  );

endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding select: nearest matching producer wins, register 0 never forwards.
module id_ex_stage_fwd_mux #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic [REG_W-1:0]  idx,
  input  logic              mem_we,
  input  logic [REG_W-1:0]  mem_reg,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              wb_we,
  input  logic [REG_W-1:0]  wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [DATA_W-1:0] stored,
  output logic [DATA_W-1:0] sel
);

  logic nonzero;
  assign nonzero = (idx != '0);

  always_comb begin
    sel = stored;
    if (nonzero && mem_we && (mem_reg == idx)) begin
      sel = mem_data;
    end else if (nonzero && wb_we && (wb_reg == idx)) begin
      sel = wb_data;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding onto the ALU inputs.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_W  = DEF_REG_W,
  parameter int OP_W   = DEF_OP_W
) (
  input  logic         clk,
  input  logic         reset_n,
  id_ex_stage_if.slave bus
);

  ctrl_t             ctrl_p0;
  logic [PC_W-1:0]   pc_p0;
  logic [DATA_W-1:0] rs_val_p0;
  logic [DATA_W-1:0] rt_val_p0;
  logic [DATA_W-1:0] imm_p0;
  logic [REG_W-1:0]  rs_p0;
  logic [REG_W-1:0]  rt_p0;
  logic [OP_W-1:0]   op_p0;
  logic [REG_W-1:0]  wreg_p0;

  logic [DATA_W-1:0] rs_fwd;
  logic [DATA_W-1:0] rt_fwd;

  id_ex_stage_fwd_mux #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd_rs (
    .idx      (rs_p0),
    .mem_we   (bus.memRegWrite),
    .mem_reg  (bus.memWriteReg),
    .mem_data (bus.memData),
    .wb_we    (bus.wbRegWrite),
    .wb_reg   (bus.wbWriteReg),
    .wb_data  (bus.wbData),
    .stored   (rs_val_p0),
    .sel      (rs_fwd)
  );

  id_ex_stage_fwd_mux #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd_rt (
    .idx      (rt_p0),
    .mem_we   (bus.memRegWrite),
    .mem_reg  (bus.memWriteReg),
    .mem_data (bus.memData),
    .wb_we    (bus.wbRegWrite),
    .wb_reg   (bus.wbWriteReg),
    .wb_data  (bus.wbData),
    .stored   (rt_val_p0),
    .sel      (rt_fwd)
  );

  // ID -> EX boundary: flush beats stall beats load; a stall re-captures forwarded values
  // so a producer retiring mid-stall is not lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_p0   <= CTRL_BUBBLE;
      pc_p0     <= '0;
      rs_val_p0 <= '0;
      rt_val_p0 <= '0;
      imm_p0    <= '0;
      rs_p0     <= '0;
      rt_p0     <= '0;
      op_p0     <= OP_W'(ALU_ADDU);
      wreg_p0   <= '0;
    end else if (bus.flush) begin
      ctrl_p0   <= CTRL_BUBBLE;
      pc_p0     <= '0;
      rs_val_p0 <= '0;
      rt_val_p0 <= '0;
      imm_p0    <= '0;
      rs_p0     <= '0;
      rt_p0     <= '0;
      op_p0     <= OP_W'(ALU_ADDU);
      wreg_p0   <= '0;
    end else if (bus.stall) begin
      rs_val_p0 <= rs_fwd;
      rt_val_p0 <= rt_fwd;
    end else begin
      ctrl_p0.valid     <= bus.idValid;
      ctrl_p0.reg_write <= bus.idRegWrite;
      ctrl_p0.src_b     <= bus.idSrcB;
      pc_p0             <= bus.idPc;
      rs_val_p0         <= bus.idRsVal;
      rt_val_p0         <= bus.idRtVal;
      imm_p0            <= bus.idImm;
      rs_p0             <= bus.idRs;
      rt_p0             <= bus.idRt;
      op_p0             <= bus.idAluOp;
      wreg_p0           <= bus.idWriteReg;
    end
  end

  assign bus.aluA       = rs_fwd;
  assign bus.exRtVal    = rt_fwd;
  assign bus.aluB       = ctrl_p0.src_b ? imm_p0 : rt_fwd;
  assign bus.aluOp      = op_p0;
  assign bus.exValid    = ctrl_p0.valid;
  assign bus.exPc       = pc_p0;
  assign bus.exRegWrite = ctrl_p0.reg_write;
  assign bus.exWriteReg = wreg_p0;

endmodule
